fir_mac_acc: RTL and testbench
==============================

// Module: fir_mac_acc
// PURPOSE
//  Multiply-accumulate back end of the FIR datapath. Sits directly downstream of the
//  unsigned array multiplier. Sums NUM_TAPS consecutive products (one per tap) into one
//  filter output sample, then scales and formats it. Hands the sample to the output stage
//  over a valid/ready handshake.
// PARAMETERS
//  NUM_TAPS   FirPkg::NUM_TAPS (default 8)   products summed per output sample, >=2
//  ACC_WIDTH  2*DATA_WIDTH+$clog2(NUM_TAPS)  internal accumulator width (never overflows)
//  OUT_SHIFT  0                              right shift applied to the final sum
//  OUT_WIDTH  2*DATA_WIDTH                   width of y_o
// PORTS
//  clk_i         in   1             clock, all state on rising edge
//  rst_ni        in   1             reset, asynchronous, active-low
//  clear_i       in   1             synchronous abort of the current sample
//  prod_valid_i  in   1             product present on prod_i
//  prod_ready_o  out  1             block accepts product this cycle
//  prod_i        in   2*DATA_WIDTH  unsigned product from the multiplier
//  y_valid_o     out  1             output sample valid
//  y_ready_i     in   1             downstream accepts y_o
//  y_o           out  OUT_WIDTH     formatted output sample
//  tap_cnt_o     out  $clog2(NUM_TAPS)  index of the next tap expected (for coefficient sequencing)
//  ovf_o         out  1             sticky: some sample did not fit in OUT_WIDTH
// BEHAVIOUR
//  - Reset (rst_ni=0, async): acc=0, tap_cnt=0, state=IDLE, y_o=0, y_valid_o=0, ovf_o=0.
//  - Handshake: product accepted when prod_valid_i & prod_ready_o. prod_i must be stable
//    while valid and not ready.
//  - FSM, 2 states:
//    IDLE  (tap_cnt==0): on accept -> acc=prod_i, tap_cnt=1, go ACCUM.
//    ACCUM: on accept -> acc+=prod_i, tap_cnt++.
//      On accept at tap_cnt==NUM_TAPS-1 -> launch sample, tap_cnt=0, go IDLE.
//  - Launch: full = acc+prod_i (ACC_WIDTH, zero-extended). sh = full>>OUT_SHIFT.
//    y_o <= fmt(sh) and y_valid_o <= 1 on the same edge. Latency is 1 cycle from the
//    last-tap accept.
//  - Output register is separate from acc. The next sample accumulates while y_valid_o
//    is held.
//  - Back-pressure: prod_ready_o = !clear_i & !(tap_cnt==NUM_TAPS-1 & y_valid_o & !y_ready_i).
//    Only the last tap stalls. Launch and pop in the same cycle is legal and gives
//    full throughput.
//  - y_valid_o clears on y_ready_i unless a new launch occurs that same edge.
//    y_o is held while y_valid_o=1 & y_ready_i=0.
//  - Overflow: if sh[ACC_WIDTH-1:OUT_WIDTH] != 0 at launch, ovf_o <= 1 (sticky).
//    ovf_o is cleared only by reset or clear_i.
//  - clear_i (priority over accept):
//    acc=0, tap_cnt=0, IDLE, y_valid_o=0, ovf_o=0.
//    A product presented that cycle is not accepted.
//  - Reset asserted mid-sample discards the partial sum. After release the first accepted
//    product is tap 0.
// CONFIGURATION
//  Macro FIR_ACC_SAT_EN:
//   defined: fmt() saturates; on overflow y_o = all ones.
//   undefined: fmt() truncates; y_o = sh[OUT_WIDTH-1:0] (wrap).
//  ovf_o behaves identically in both builds.
// STRUCTURE
//  FirPkg: NUM_TAPS, ACC_WIDTH localparam, typedefs prod_t [2*DATA_WIDTH-1:0],
//  acc_t [ACC_WIDTH-1:0], tap_idx_t, enum fir_acc_state_e {IDLE, ACCUM}.
//  Sub-module fir_acc_fmt: combinational shift + overflow detect + sat/trunc
//  (holds the FIR_ACC_SAT_EN ifdef).
//  Accumulator adder is plain +, not the ripple adder.
// TESTING  (DATA_WIDTH=8, NUM_TAPS=4, OUT_SHIFT=0, OUT_WIDTH=16)
//  1. Products 1,2,3,4 back-to-back, y_ready_i=1 -> y_o=10, y_valid_o high 1 cycle after
//     4th accept, ovf_o=0.
//  2. Products 65025 x4 -> full=260100.
//     SAT build: y_o=65535, ovf_o=1. Non-SAT build: y_o=63492, ovf_o=1.
//  3. y_ready_i=0 after sample A=10; send 4x1:
//     3 taps accepted, prod_ready_o=0 on 4th until y_ready_i=1.
//     Then y_o=4 next cycle, no sample lost.
//  4. Accept 7,7, pulse clear_i (with prod_valid_i=1, value 9 not accepted), then 5,5,5,5
//     -> y_o=20, ovf_o=0.
//  5. Random prod_valid_i bubbles on 1,2,3,4 plus random y_ready_i -> y_o=10.
//     tap_cnt_o tracks 0..3 and wraps.
//  6. rst_ni low mid-sample after 2 taps -> all outputs 0 immediately (async).
//     After release, products 2,2,2,2 give y_o=8.

Source files
------------

// File: rtl/fir_mac_acc_pkg.sv
// rtl/fir_mac_acc_pkg.sv - shared widths, types and FSM states for the FIR MAC back end
package fir_mac_acc_pkg;

  localparam int DATA_WIDTH = 8;
  localparam int NUM_TAPS   = 8;
  localparam int ACC_WIDTH  = 2*DATA_WIDTH + $clog2(NUM_TAPS);

  typedef logic [2*DATA_WIDTH-1:0]     prod_t;
  typedef logic [ACC_WIDTH-1:0]        acc_t;
  typedef logic [$clog2(NUM_TAPS)-1:0] tap_idx_t;

  typedef enum logic {
    IDLE,
    ACCUM
  } fir_acc_state_e;

endpackage

// File: rtl/fir_mac_acc_fmt.sv
// rtl/fir_mac_acc_fmt.sv - output shift, overflow detect and wrap/saturate formatting
// FIR_ACC_SAT_EN selects saturation on overflow; otherwise the sample wraps.
module fir_mac_acc_fmt #(
  parameter int ACC_WIDTH = 19,
  parameter int OUT_SHIFT = 0,
  parameter int OUT_WIDTH = 16
) (
  input  logic [ACC_WIDTH-1:0] full_i,
  output logic [OUT_WIDTH-1:0] y_o,
  output logic                 ovf_o
);

  logic [ACC_WIDTH-1:0] sh;

  assign sh = full_i >> OUT_SHIFT;

  generate
    if (OUT_WIDTH < ACC_WIDTH) begin : g_narrow
      assign ovf_o = |sh[ACC_WIDTH-1:OUT_WIDTH];
`ifdef FIR_ACC_SAT_EN
      assign y_o = ovf_o ? {OUT_WIDTH{1'b1}} : sh[OUT_WIDTH-1:0];
`else
      assign y_o = sh[OUT_WIDTH-1:0];
`endif
    end else begin : g_wide
      assign ovf_o = 1'b0;
      assign y_o   = OUT_WIDTH'(sh);
    end
  endgenerate

endmodule

// File: rtl/fir_mac_acc.sv
// rtl/fir_mac_acc.sv - sums NUM_TAPS products per output sample and hands it downstream
// Output formatting is wrap by default, saturate when FIR_ACC_SAT_EN is defined.
module fir_mac_acc
  import fir_mac_acc_pkg::*;
#(
  parameter int NUM_TAPS   = fir_mac_acc_pkg::NUM_TAPS,
  parameter int DATA_WIDTH = fir_mac_acc_pkg::DATA_WIDTH,
  parameter int OUT_SHIFT  = 0,
  parameter int OUT_WIDTH  = 2*DATA_WIDTH
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        clear_i,
  input  logic                        prod_valid_i,
  output logic                        prod_ready_o,
  input  logic [2*DATA_WIDTH-1:0]     prod_i,
  output logic                        y_valid_o,
  input  logic                        y_ready_i,
  output logic [OUT_WIDTH-1:0]        y_o,
  output logic [$clog2(NUM_TAPS)-1:0] tap_cnt_o,
  output logic                        ovf_o
);

  localparam int AW = 2*DATA_WIDTH + $clog2(NUM_TAPS);
  localparam int TW = $clog2(NUM_TAPS);
  localparam logic [TW-1:0] LAST_TAP = TW'(NUM_TAPS-1);

  fir_acc_state_e state_q, state_d;
  logic [TW-1:0]  tap_cnt_q, tap_cnt_d;
  logic [AW-1:0]  acc_q, acc_d, full;
  logic [OUT_WIDTH-1:0] y_q, y_d, y_fmt;
  logic y_valid_q, y_valid_d, ovf_q, ovf_d, fmt_ovf;
  logic last_tap, accept, launch;

  // Only the closing tap needs a free output register, so only it stalls.
  assign last_tap     = (tap_cnt_q == LAST_TAP);
  assign prod_ready_o = !clear_i && !(last_tap && y_valid_q && !y_ready_i);
  assign accept       = prod_valid_i && prod_ready_o;
  assign full         = acc_q + AW'(prod_i);
  assign launch       = accept && (state_q == ACCUM) && last_tap;

  fir_mac_acc_fmt #(
    .ACC_WIDTH (AW),
    .OUT_SHIFT (OUT_SHIFT),
    .OUT_WIDTH (OUT_WIDTH)
  ) u_fmt (
    .full_i (full),
    .y_o    (y_fmt),
    .ovf_o  (fmt_ovf)
  );

  always_comb begin
    state_d   = state_q;
    tap_cnt_d = tap_cnt_q;
    acc_d     = acc_q;
    if (clear_i) begin
      state_d   = IDLE;
      tap_cnt_d = '0;
      acc_d     = '0;
    end else if (accept) begin
      case (state_q)
        IDLE: begin
          acc_d     = AW'(prod_i);
          tap_cnt_d = TW'(1);
          state_d   = ACCUM;
        end
        ACCUM: begin
          if (last_tap) begin
            acc_d     = '0;
            tap_cnt_d = '0;
            state_d   = IDLE;
          end else begin
            acc_d     = full;
            tap_cnt_d = tap_cnt_q + TW'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // A launch wins over a pop on the same edge, giving back-to-back samples.
  always_comb begin
    y_d       = y_q;
    y_valid_d = y_valid_q;
    ovf_d     = ovf_q;
    if (clear_i) begin
      y_valid_d = 1'b0;
      ovf_d     = 1'b0;
    end else if (launch) begin
      y_d       = y_fmt;
      y_valid_d = 1'b1;
      ovf_d     = ovf_q | fmt_ovf;
    end else if (y_ready_i) begin
      y_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      tap_cnt_q <= '0;
      acc_q     <= '0;
      y_q       <= '0;
      y_valid_q <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      tap_cnt_q <= tap_cnt_d;
      acc_q     <= acc_d;
      y_q       <= y_d;
      y_valid_q <= y_valid_d;
      ovf_q     <= ovf_d;
    end
  end

  assign y_o       = y_q;
  assign y_valid_o = y_valid_q;
  assign tap_cnt_o = tap_cnt_q;
  assign ovf_o     = ovf_q;

endmodule

// File: tb/tb_fir_mac_acc.sv
// tb/tb_fir_mac_acc.sv - directed scoreboard bench for fir_mac_acc (DATA_WIDTH=8, NUM_TAPS=4)
module tb_fir_mac_acc;

  logic        clk = 1'b0;
  logic        rst_ni, clear, prod_valid, prod_ready, y_valid, y_ready, ovf;
  logic [15:0] prod, y;
  logic [1:0]  tap_cnt;

  int checks   = 0;
  int failures = 0;
  logic [15:0] exp_q[$];

  always #5 clk = ~clk;

  fir_mac_acc #(
    .NUM_TAPS   (4),
    .DATA_WIDTH (8),
    .OUT_SHIFT  (0),
    .OUT_WIDTH  (16)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_ni),
    .clear_i      (clear),
    .prod_valid_i (prod_valid),
    .prod_ready_o (prod_ready),
    .prod_i       (prod),
    .y_valid_o    (y_valid),
    .y_ready_i    (y_ready),
    .y_o          (y),
    .tap_cnt_o    (tap_cnt),
    .ovf_o        (ovf)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_ni && y_valid && y_ready) begin
      if (exp_q.size() == 0) check("sb_unexpected_y", {16'h0001, y}, 32'h0);
      else check("sb_y", {16'h0, y}, {16'h0, exp_q.pop_front()});
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [15:0] v, input bit rnd_ready);
    int  n;
    bit  acc;
    n   = 0;
    acc = 1'b0;
    prod_valid = 1'b1;
    prod       = v;
    while (!acc && n < 50) begin
      if (rnd_ready) y_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      acc = prod_ready;
      @(posedge clk);
      #1;
      n++;
    end
    prod_valid = 1'b0;
    check("prod_accepted", {31'h0, acc}, 32'd1);
  endtask

  initial begin
    rst_ni = 1'b0; clear = 1'b0; prod_valid = 1'b0; prod = '0; y_ready = 1'b1;
    #2;
    check("rst_y_valid", y_valid, 0);
    check("rst_y", y, 0);
    check("rst_ovf", ovf, 0);
    check("rst_tap", tap_cnt, 0);
    @(posedge clk); #1;
    rst_ni = 1'b1;

    // 1: basic sum, one-cycle latency
    exp_q.push_back(16'd10);
    send(1, 0); send(2, 0); send(3, 0);
    check("t1_tap3", tap_cnt, 3);
    send(4, 0);
    check("t1_valid_lat", y_valid, 1);
    check("t1_y", y, 10);
    check("t1_ovf", ovf, 0);
    check("t1_tap_wrap", tap_cnt, 0);
    @(posedge clk); #1;
    check("t1_valid_drop", y_valid, 0);

    // 2: overflow
`ifdef FIR_ACC_SAT_EN
    exp_q.push_back(16'd65535);
`else
    exp_q.push_back(16'd63492);
`endif
    for (int i = 0; i < 4; i++) send(16'd65025, 0);
    check("t2_ovf", ovf, 1);
    @(posedge clk); #1;
    check("t2_ovf_sticky", ovf, 1);

    // 3: back-pressure on the last tap only
    y_ready = 1'b0;
    exp_q.push_back(16'd10);
    send(1, 0); send(2, 0); send(3, 0); send(4, 0);
    repeat (2) begin @(posedge clk); #1; end
    check("t3_hold_valid", y_valid, 1);
    check("t3_hold_y", y, 10);
    exp_q.push_back(16'd4);
    send(1, 0); send(1, 0); send(1, 0);
    check("t3_tap3", tap_cnt, 3);
    prod_valid = 1'b1;
    prod       = 16'd1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t3_stall", prod_ready, 0);
      @(posedge clk); #1;
    end
    y_ready = 1'b1;
    send(1, 0);
    check("t3_valid", y_valid, 1);
    check("t3_y", y, 4);

    // 4: clear aborts partial sum and drops the concurrent product
    send(7, 0); send(7, 0);
    clear = 1'b1; prod_valid = 1'b1; prod = 16'd9;
    @(negedge clk);
    check("t4_clear_not_ready", prod_ready, 0);
    @(posedge clk); #1;
    clear = 1'b0; prod_valid = 1'b0;
    check("t4_tap", tap_cnt, 0);
    check("t4_ovf_cleared", ovf, 0);
    check("t4_valid_cleared", y_valid, 0);
    exp_q.push_back(16'd20);
    for (int i = 0; i < 4; i++) send(5, 0);
    check("t4_y", y, 20);
    check("t4_ovf", ovf, 0);

    // 5: random bubbles and random downstream ready
    exp_q.push_back(16'd10);
    for (int i = 0; i < 4; i++) begin
      repeat ($urandom_range(0, 2)) begin
        y_ready = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
      end
      check("t5_tap", tap_cnt, i);
      send(16'(i + 1), 1);
    end
    check("t5_tap_wrap", tap_cnt, 0);
    y_ready = 1'b1;
    repeat (3) begin @(posedge clk); #1; end

    // 6: async reset mid-sample
    y_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(16'd65025, 0);
    check("t6_pre_valid", y_valid, 1);
    check("t6_pre_ovf", ovf, 1);
    send(1, 0); send(1, 0);
    check("t6_pre_tap", tap_cnt, 2);
    @(negedge clk);
    rst_ni = 1'b0;
    #1;
    check("t6_rst_valid", y_valid, 0);
    check("t6_rst_y", y, 0);
    check("t6_rst_ovf", ovf, 0);
    check("t6_rst_tap", tap_cnt, 0);
    @(posedge clk); #1;
    rst_ni  = 1'b1;
    y_ready = 1'b1;
    exp_q.push_back(16'd8);
    for (int i = 0; i < 4; i++) send(2, 0);
    check("t6_y", y, 8);

    repeat (4) begin @(posedge clk); #1; end
    check("sb_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
